sin_lut: RTL and testbench

- Pipelined sine generator for the FOC datapath. Maps an unsigned 16-bit electrical phase, where 0..65535 covers one full turn [0, 2π), to a signed Q1.15 sine value.
- Uses a quarter-wave ROM with quadrant folding and linear interpolation between ROM points.
- Feeds the Park/inverse-Park and SVPWM stages. A cosine is obtained by instantiating the block with phase + 16384.

---
 rtl/sin_lut_pkg.sv | 40 ++++
 rtl/sin_quarter_rom.sv | 38 +++
 rtl/sin_lut.sv | 107 ++++++++++
 tb/tb_sin_lut.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sin_lut_pkg.sv
// Shared constants and the quarter-wave table generator for the sin_lut sine block.
// The table is built at elaboration time with integer-only arithmetic.
package sin_lut_pkg;

   localparam int PH_W    = 16;
   localparam int OUT_W   = 16;
   localparam int LUT_AW  = 8;
   localparam int LATENCY = 3;
   localparam int ROM_W   = OUT_W - 1;
   localparam int AMP     = (2 ** (OUT_W - 1)) - 1;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   // round(amp * sin(j*pi/2^(lut_aw+1))) by a Taylor series in 2^30 fixed point
   function automatic int rom_entry(input int j, input int lut_aw, input int amp);
      longint scale;
      longint pi_s;
      longint x;
      longint term;
      longint sum;
      scale = longint'(1) << 30;
      pi_s  = 64'sd3373259426;
      x     = (longint'(j) * pi_s) / (longint'(2) << lut_aw);
      term  = x;
      sum   = x;
      for (int n = 1; n <= 9; n++) begin
         term = (term * x) / scale;
         term = (term * x) / scale;
         term = -term / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return int'((sum * longint'(amp) + scale / 2) / scale);
   endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// Constant quarter-wave sine table with two registered read ports (k and k+1).
// The upper port saturates at the last entry so the table is never overrun.
module sin_quarter_rom #(
   parameter int AW  = sin_lut_pkg::LUT_AW,
   parameter int DW  = sin_lut_pkg::ROM_W,
   parameter int AMP = sin_lut_pkg::AMP
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW:0]   addr,
   output logic [DW-1:0] t0,
   output logic [DW-1:0] t1
);

   localparam int          N    = (1 << AW) + 1;
   localparam logic [AW:0] LAST = (AW + 1)'(N - 1);

   logic [DW-1:0] rom [N];
   logic [AW:0]   addr_nx;

   for (genvar j = 0; j < N; j++) begin : g_rom
      localparam logic [DW-1:0] V = DW'(sin_lut_pkg::rom_entry(j, AW, AMP));
      assign rom[j] = V;
   end

   assign addr_nx = (addr == LAST) ? addr : addr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t0 <= '0;
         t1 <= '0;
      end else begin
         t0 <= rom[addr];
         t1 <= rom[addr_nx];
      end
   end

endmodule

// File: rtl/sin_lut.sv
// Three-stage pipelined sine: quadrant fold, quarter-wave table read, linear interpolation.
// Phase 0..2^PH_W-1 spans one turn; output is signed Q1.15 with peak 32767.
module sin_lut #(
   parameter int PH_W   = sin_lut_pkg::PH_W,
   parameter int OUT_W  = sin_lut_pkg::OUT_W,
   parameter int LUT_AW = sin_lut_pkg::LUT_AW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PH_W-1:0]         i_ph,
   output logic signed [OUT_W-1:0] o_sin
);
   import sin_lut_pkg::*;

   localparam int          QW      = PH_W - 2;
   localparam int          FW      = QW - LUT_AW;
   localparam int          KW      = LUT_AW + 1;
   localparam int          RW      = OUT_W - 1;
   localparam logic [QW:0] QUARTER = (QW + 1)'(1) << QW;

   function automatic logic [RW-1:0] interp(input logic [RW-1:0] a,
                                            input logic [RW-1:0] b,
                                            input logic [FW-1:0] fr);
      logic [RW+FW-1:0] prod;
      prod = (RW + FW)'(b - a) * (RW + FW)'(fr);
      return a + RW'(prod >> FW);
   endfunction

   function automatic logic signed [OUT_W-1:0] apply_sign(input logic [RW-1:0] mag,
                                                          input logic n);
      logic signed [OUT_W-1:0] s;
      s = signed'({1'b0, mag});
      return n ? -s : s;
   endfunction

   quad_e         q;
   logic [QW:0]   idx;
   logic          neg;
   logic [KW-1:0] k_p1;
   logic [FW-1:0] frac_p1;
   logic          neg_p1;
   logic [RW-1:0] t0_p2;
   logic [RW-1:0] t1_p2;
   logic [FW-1:0] frac_p2;
   logic          neg_p2;

   always_comb begin
      q   = quad_e'(i_ph[PH_W-1 -: 2]);
      idx = {1'b0, i_ph[QW-1:0]};
      neg = 1'b0;
      unique case (q)
         Q0: idx = {1'b0, i_ph[QW-1:0]};
         Q1: idx = QUARTER - {1'b0, i_ph[QW-1:0]};
         Q2: neg = 1'b1;
         Q3: begin
            idx = QUARTER - {1'b0, i_ph[QW-1:0]};
            neg = 1'b1;
         end
      endcase
   end

   // stage 1: folded table address, fraction and sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_p1    <= '0;
         frac_p1 <= '0;
         neg_p1  <= 1'b0;
      end else begin
         k_p1    <= idx[QW -: KW];
         frac_p1 <= idx[FW-1:0];
         neg_p1  <= neg;
      end
   end

   // stage 2: table entries k and k+1
   sin_quarter_rom #(
      .AW  (LUT_AW),
      .DW  (RW),
      .AMP ((2 ** (OUT_W - 1)) - 1)
   ) u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr (k_p1),
      .t0   (t0_p2),
      .t1   (t1_p2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frac_p2 <= '0;
         neg_p2  <= 1'b0;
      end else begin
         frac_p2 <= frac_p1;
         neg_p2  <= neg_p1;
      end
   end

   // stage 3: interpolate and restore sign
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_sin <= '0;
      end else begin
         o_sin <= apply_sign(interp(t0_p2, t1_p2, frac_p2), neg_p2);
      end
   end

endmodule

// File: tb/tb_sin_lut.sv
// Directed bench for sin_lut: reset, cardinal points, sweep, symmetry, streaming, mid-stream reset.
// Expected values come from a reference table model and from the ideal real-valued sine.
module tb_sin_lut;
   import sin_lut_pkg::*;

   localparam real PI = 3.14159265358979323846;
   localparam int  NB = LATENCY + 1;

   logic                clk;
   logic                rst;
   logic [15:0]         i_ph;
   logic signed [15:0]  o_sin;

   sin_lut dut (
      .clk   (clk),
      .rst   (rst),
      .i_ph  (i_ph),
      .o_sin (o_sin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int tbl [257];
   int ph_buf [NB];
   int kexp_buf [NB];
   bit kuse_buf [NB];
   bit mono_buf [NB];
   int out_log [int];
   int odd_idx [$];
   int mir_idx [$];
   int t;
   int fill;
   int prev_out;
   bit prev_valid;

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      n_checks++;
      if (obs - exp > tol || exp - obs > tol)
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
      else
         n_pass++;
   endtask

   function automatic int model(input int ph);
      int q, f, idx, k, fr, a, b, y;
      q   = ph >> 14;
      f   = ph & 16383;
      idx = ((q & 1) != 0) ? 16384 - f : f;
      k   = idx >> 6;
      fr  = idx & 63;
      a   = tbl[k];
      b   = (k == 256) ? tbl[256] : tbl[k + 1];
      y   = a + ((b - a) * fr) / 64;
      return ((q & 2) != 0) ? -y : y;
   endfunction

   function automatic int ideal(input int ph);
      return int'($floor(32767.0 * $sin(2.0 * PI * real'(ph) / 65536.0) + 0.5));
   endfunction

   // Entered at a falling edge: sample the result of the phase driven LATENCY ticks ago,
   // drive the next phase, then move to the following falling edge.
   task automatic tick(input int ph, input int kexp = 0, input bit kuse = 0, input bit mono = 0);
      int o, slot, p;
      o = int'(o_sin);
      if (fill >= LATENCY) begin
         slot = (t - LATENCY) % NB;
         p    = ph_buf[slot];
         check("model", o, model(p), 0);
         check("accuracy", o, ideal(p), 2);
         if (kuse_buf[slot]) check("spot", o, kexp_buf[slot], 0);
         if (mono_buf[slot] && prev_valid) check("mono", int'(o < prev_out), 0, 0);
         out_log[t - LATENCY] = o;
         prev_out   = o;
         prev_valid = mono_buf[slot];
      end else begin
         check("fill_zero", o, 0, 0);
      end
      slot           = t % NB;
      ph_buf[slot]   = ph;
      kexp_buf[slot] = kexp;
      kuse_buf[slot] = kuse;
      mono_buf[slot] = mono;
      i_ph           = 16'(ph);
      t++;
      if (fill < LATENCY) fill++;
      @(negedge clk);
   endtask

   int card_ph  [6] = '{0, 8192, 16384, 32768, 40960, 49152};
   int card_exp [6] = '{0, 23170, 32767, 0, -23170, -32767};

   initial begin
      for (int j = 0; j <= 256; j++)
         tbl[j] = int'($floor(32767.0 * $sin(real'(j) * PI / 512.0) + 0.5));
      t          = 0;
      fill       = 0;
      prev_valid = 1'b0;
      prev_out   = 0;
      rst        = 1'b1;
      i_ph       = 16'd16384;

      repeat (5) begin
         @(negedge clk);
         check("rst_hold", int'(o_sin), 0, 0);
      end
      rst = 1'b0;
      tick(16384, 32767, 1);

      for (int i = 0; i < 6; i++) tick(card_ph[i], card_exp[i], 1);

      for (int p = 0; p <= 16384; p++) tick(p, 0, 0, 1);
      for (int p = 16385; p <= 65534; p += 3) tick(p);
      tick(65535, -3, 1);
      tick(0, 0, 1);
      tick(1, 3, 1);

      for (int i = 0; i < 200; i++) tick(int'($urandom_range(0, 65535)));

      #2 rst = 1'b1;
      #1 check("async_rst", int'(o_sin), 0, 0);
      @(negedge clk);
      check("rst_hold", int'(o_sin), 0, 0);
      rst        = 1'b0;
      fill       = 0;
      prev_valid = 1'b0;
      tick(16384, 32767, 1);
      for (int i = 0; i < 30; i++) tick(int'($urandom_range(0, 65535)));

      for (int i = 0; i < 12; i++) begin
         int p;
         p = int'($urandom_range(0, 32767));
         odd_idx.push_back(t);
         tick(p);
         tick(p + 32768);
         p = int'($urandom_range(0, 16384));
         mir_idx.push_back(t);
         tick(16384 - p);
         tick(16384 + p);
      end
      repeat (LATENCY) tick(0);

      foreach (odd_idx[i]) check("odd_sym", out_log[odd_idx[i] + 1], -out_log[odd_idx[i]], 0);
      foreach (mir_idx[i]) check("mirror_sym", out_log[mir_idx[i] + 1], out_log[mir_idx[i]], 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
